// File: rtl/regfile_writeback_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback_pkg                                                |
// | Shared defaults, write-request record and selection encoding for the |
// | register-file writeback arbiter.                                     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package regfile_writeback_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;
  localparam int WB_QDEPTH = 4;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

endpackage
`default_nettype wire

// File: rtl/regfile_writeback_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_fifo                                                              |
// | Load-return queue with full/empty flags and age-ordered visibility   |
// | of every entry (index 0 = oldest) for the bypass lookup.             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module wb_fifo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_push,
  input  logic [ADDR_W-1:0]             i_push_rd,
  input  logic [DATA_W-1:0]             i_push_data,
  input  logic                          i_pop,
  output logic [ADDR_W-1:0]             o_head_rd,
  output logic [DATA_W-1:0]             o_head_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [QDEPTH-1:0]             o_ent_vld,
  output logic [QDEPTH-1:0][ADDR_W-1:0] o_ent_rd,
  output logic [QDEPTH-1:0][DATA_W-1:0] o_ent_data
);

  localparam int IW = $clog2(QDEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [PW-1:0]     w_count;
  logic              w_do_push;
  logic              w_do_pop;
  logic [ADDR_W-1:0] r_rd_mem   [QDEPTH];
  logic [DATA_W-1:0] r_data_mem [QDEPTH];

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_full    = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
  assign o_empty   = (r_wptr == r_rptr);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_count   = r_wptr - r_rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_rd_mem[r_wptr[IW-1:0]]   <= i_push_rd;
      r_data_mem[r_wptr[IW-1:0]] <= i_push_data;
    end
  end

  assign o_head_rd   = r_rd_mem[r_rptr[IW-1:0]];
  assign o_head_data = r_data_mem[r_rptr[IW-1:0]];

  for (genvar i = 0; i < QDEPTH; i++) begin : g_ent
    logic [IW-1:0] w_slot;
    assign w_slot        = r_rptr[IW-1:0] + IW'(i);
    assign o_ent_vld[i]  = (PW'(i) < w_count);
    assign o_ent_rd[i]   = r_rd_mem[w_slot];
    assign o_ent_data[i] = r_data_mem[w_slot];
  end

endmodule
`default_nettype wire

// File: rtl/regfile_writeback.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_writeback                                                    |
// | Arbitrates ALU results and queued load returns onto one registered   |
// | register-file write port. Optional bypass: REGFILE_WB_BYPASS_EN.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  parameter int QDEPTH = WB_QDEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              hit_rs,
  output logic              hit_rt,
  output logic [DATA_W-1:0] fwd_rs,
  output logic [DATA_W-1:0] fwd_rt
);

  logic                          w_full;
  logic                          w_empty;
  logic                          w_push;
  logic                          w_pop;
  logic [ADDR_W-1:0]             w_head_rd;
  logic [DATA_W-1:0]             w_head_data;
  logic [QDEPTH-1:0]             w_ent_vld;
  logic [QDEPTH-1:0][ADDR_W-1:0] w_ent_rd;
  logic [QDEPTH-1:0][DATA_W-1:0] w_ent_data;
  wb_sel_e                       w_sel;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_rd;
  logic [DATA_W-1:0] r_wr_data;

  wb_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_rd   (mem_rd),
    .i_push_data (mem_data),
    .i_pop       (w_pop),
    .o_head_rd   (w_head_rd),
    .o_head_data (w_head_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_ent_vld   (w_ent_vld),
    .o_ent_rd    (w_ent_rd),
    .o_ent_data  (w_ent_data)
  );

  // A full queue always drains first so load returns cannot be starved.
  always_comb begin
    w_sel = SEL_NONE;
    if (w_full)          w_sel = SEL_FIFO;
    else if (alu_valid)  w_sel = SEL_ALU;
    else if (!w_empty)   w_sel = SEL_FIFO;
  end

  assign alu_ready = rst_n & ~w_full;
  assign mem_ready = rst_n & ~w_full;
  assign w_push    = mem_valid & mem_ready;
  assign w_pop     = (w_sel == SEL_FIFO);

  // Destination 0 still consumes its slot but never raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          r_wr_en   <= (alu_rd != '0);
          r_wr_rd   <= alu_rd;
          r_wr_data <= alu_data;
        end
        SEL_FIFO: begin
          r_wr_en   <= (w_head_rd != '0);
          r_wr_rd   <= w_head_rd;
          r_wr_data <= w_head_data;
        end
        default: r_wr_en <= 1'b0;
      endcase
    end
  end

  assign RegWrite = r_wr_en;
  assign rd       = r_wr_rd;
  assign in       = r_wr_data;

`ifdef REGFILE_WB_BYPASS_EN
  // Later (younger) matches overwrite earlier ones, giving youngest-first priority.
  function automatic logic [DATA_W:0] f_lookup(
    input logic [ADDR_W-1:0]             i_q,
    input logic                          i_out_en,
    input logic [ADDR_W-1:0]             i_out_rd,
    input logic [DATA_W-1:0]             i_out_data,
    input logic [QDEPTH-1:0]             i_vld,
    input logic [QDEPTH-1:0][ADDR_W-1:0] i_rd,
    input logic [QDEPTH-1:0][DATA_W-1:0] i_data
  );
    logic [DATA_W:0] res;
    res = '0;
    if (i_out_en && (i_out_rd == i_q)) res = {1'b1, i_out_data};
    for (int k = 0; k < QDEPTH; k++) begin
      if (i_vld[k] && (i_rd[k] != '0) && (i_rd[k] == i_q)) res = {1'b1, i_data[k]};
    end
    return res;
  endfunction

  assign {hit_rs, fwd_rs} = f_lookup(q_rs, r_wr_en, r_wr_rd, r_wr_data,
                                     w_ent_vld, w_ent_rd, w_ent_data);
  assign {hit_rt, fwd_rt} = f_lookup(q_rt, r_wr_en, r_wr_rd, r_wr_data,
                                     w_ent_vld, w_ent_rd, w_ent_data);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{q_rs, q_rt, w_ent_vld, w_ent_rd, w_ent_data};
  assign hit_rs = 1'b0;
  assign hit_rt = 1'b0;
  assign fwd_rs = '0;
  assign fwd_rt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// Testbench for regfile_writeback: table vectors, hand-written corner
// sequences and randomized traffic against a queue-based reference model.
module tb_regfile_writeback;
  import regfile_writeback_pkg::*;

  localparam int QD = WB_QDEPTH;
`ifdef REGFILE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, q_rs, q_rt;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, d_regwrite, hit_rs, hit_rt;
  logic [4:0]  d_rd;
  logic [31:0] d_in, fwd_rs, fwd_rt;

  regfile_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .RegWrite(d_regwrite), .rd(d_rd), .in(d_in),
    .q_rs(q_rs), .q_rt(q_rt), .hit_rs(hit_rs), .hit_rt(hit_rt),
    .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  wb_req_t     m_q[$];
  bit          m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  bit          m_acc_alu, m_acc_mem;

  task automatic model_reset();
    m_q.delete();
    m_we = 1'b0; m_rd = '0; m_data = '0;
    m_acc_alu = 1'b0; m_acc_mem = 1'b0;
  endtask

  task automatic model_step();
    wb_req_t w;
    bit full;
    full = (m_q.size() == QD);
    m_acc_alu = alu_valid && !full;
    m_acc_mem = mem_valid && !full;
    if (full || (!alu_valid && m_q.size() != 0)) begin
      w = m_q.pop_front();
      m_we = (w.rd != 0); m_rd = w.rd; m_data = w.data;
    end else if (alu_valid) begin
      m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
    end else begin
      m_we = 1'b0;
    end
    if (m_acc_mem) begin
      w.rd = mem_rd; w.data = mem_data;
      m_q.push_back(w);
    end
  endtask

  task automatic model_byp(input logic [4:0] q, output bit hit, output logic [31:0] fwd);
    hit = 1'b0; fwd = '0;
    if (BYP) begin
      for (int k = m_q.size() - 1; k >= 0; k--) begin
        if (!hit && m_q[k].rd != 0 && m_q[k].rd == q) begin
          hit = 1'b1; fwd = m_q[k].data;
        end
      end
      if (!hit && m_we && m_rd == q) begin
        hit = 1'b1; fwd = m_data;
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit          h;
    logic [31:0] f;
    check({tag, ".alu_ready"}, 32'(alu_ready), 32'(m_q.size() != QD));
    check({tag, ".mem_ready"}, 32'(mem_ready), 32'(m_q.size() != QD));
    check({tag, ".RegWrite"}, 32'(d_regwrite), 32'(m_we));
    if (m_we) begin
      check({tag, ".rd"}, 32'(d_rd), 32'(m_rd));
      check({tag, ".in"}, d_in, m_data);
    end
    model_byp(q_rs, h, f);
    check({tag, ".hit_rs"}, 32'(hit_rs), 32'(h));
    check({tag, ".fwd_rs"}, fwd_rs, f);
    model_byp(q_rt, h, f);
    check({tag, ".hit_rt"}, 32'(hit_rt), 32'(h));
    check({tag, ".fwd_rt"}, fwd_rt, f);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av; logic [4:0] ard; logic [31:0] ad;
    logic        mv; logic [4:0] mrd; logic [31:0] md;
    logic        e_rw; logic [4:0] e_rd; logic [31:0] e_in;
    logic        e_ar; logic e_mr;
  } vec_t;

  function automatic vec_t mkv(logic av, logic [4:0] ard, logic [31:0] ad,
                               logic mv, logic [4:0] mrd, logic [31:0] md,
                               logic rw, logic [4:0] erd, logic [31:0] ein,
                               logic ar, logic mr);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.mv = mv; v.mrd = mrd; v.md = md;
    v.e_rw = rw; v.e_rd = erd; v.e_in = ein; v.e_ar = ar; v.e_mr = mr;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin : wd
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [4:0]  exp_rd[$];
    logic [31:0] exp_dat[$];
    int          widx;

    tbl[0]  = mkv(1, 3, 32'hA5,  0, 0, 0,         1, 3, 32'hA5,  1, 1);
    tbl[1]  = mkv(1, 0, 32'hFF,  0, 0, 0,         0, 0, 0,       1, 1);
    tbl[2]  = mkv(0, 0, 0,       0, 0, 0,         0, 0, 0,       1, 1);
    tbl[3]  = mkv(1, 5, 32'h10,  1, 1, 32'h101,   1, 5, 32'h10,  1, 1);
    tbl[4]  = mkv(1, 6, 32'h20,  1, 2, 32'h102,   1, 6, 32'h20,  1, 1);
    tbl[5]  = mkv(1, 7, 32'h30,  1, 3, 32'h103,   1, 7, 32'h30,  1, 1);
    tbl[6]  = mkv(1, 8, 32'h40,  1, 4, 32'h104,   1, 8, 32'h40,  0, 0);
    tbl[7]  = mkv(1, 9, 32'h50,  0, 0, 0,         1, 1, 32'h101, 1, 1);
    tbl[8]  = mkv(1, 9, 32'h50,  0, 0, 0,         1, 9, 32'h50,  1, 1);
    tbl[9]  = mkv(0, 0, 0,       0, 0, 0,         1, 2, 32'h102, 1, 1);
    tbl[10] = mkv(0, 0, 0,       1, 0, 32'h77,    1, 3, 32'h103, 1, 1);
    tbl[11] = mkv(0, 0, 0,       0, 0, 0,         1, 4, 32'h104, 1, 1);
    tbl[12] = mkv(0, 0, 0,       0, 0, 0,         0, 0, 0,       1, 1);
    tbl[13] = mkv(0, 0, 0,       0, 0, 0,         0, 0, 0,       1, 1);
    tbl[14] = mkv(0, 0, 0,       1, 10, 32'hAA,   0, 0, 0,       1, 1);
    tbl[15] = mkv(0, 0, 0,       0, 0, 0,         1, 10, 32'hAA, 1, 1);

    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    q_rs = 5'd0; q_rt = 5'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.RegWrite", 32'(d_regwrite), 0);
    check("rst.rd", 32'(d_rd), 0);
    check("rst.in", d_in, 0);
    check("rst.alu_ready", 32'(alu_ready), 0);
    check("rst.mem_ready", 32'(mem_ready), 0);
    check("rst.hit_rs", 32'(hit_rs), 0);
    check("rst.hit_rt", 32'(hit_rt), 0);
    rst_n = 1'b1;
    #1;
    check("rel.alu_ready", 32'(alu_ready), 1);
    check("rel.mem_ready", 32'(mem_ready), 1);

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].mv, tbl[i].mrd, tbl[i].md);
      tick();
      check($sformatf("vec%0d.RegWrite", i), 32'(d_regwrite), 32'(tbl[i].e_rw));
      if (tbl[i].e_rw) begin
        check($sformatf("vec%0d.rd", i), 32'(d_rd), 32'(tbl[i].e_rd));
        check($sformatf("vec%0d.in", i), d_in, tbl[i].e_in);
      end
      check($sformatf("vec%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ar));
      check($sformatf("vec%0d.mem_ready", i), 32'(mem_ready), 32'(tbl[i].e_mr));
    end

    // Two same-rd loads queued behind an ALU stream; youngest must be forwarded.
    set_in(1, 9, 32'h99, 1, 7, 32'h11); tick();
    set_in(1, 9, 32'h9A, 1, 7, 32'h22); tick();
    q_rs = 5'd7; q_rt = 5'd9;
    #1;
    check("byp.hit_rs", 32'(hit_rs), 32'(BYP));
    check("byp.fwd_rs", fwd_rs, BYP ? 32'h22 : 32'h0);
    check("byp.hit_rt", 32'(hit_rt), 32'(BYP));
    check("byp.fwd_rt", fwd_rt, BYP ? 32'h9A : 32'h0);
    q_rs = 5'd3;
    #1;
    check("byp.miss_hit", 32'(hit_rs), 0);
    check("byp.miss_fwd", fwd_rs, 0);
    q_rs = 5'd7; q_rt = 5'd0;
    set_in(0, 0, 0, 0, 0, 0); tick();
    check("byp.drain1_rd", 32'(d_rd), 7);
    check("byp.drain1_in", d_in, 32'h11);
    check("byp.fifo_over_out", fwd_rs, BYP ? 32'h22 : 32'h0);
    tick();
    check("byp.drain2_in", d_in, 32'h22);
    check("byp.out_fwd", fwd_rs, BYP ? 32'h22 : 32'h0);
    tick();
    check("byp.idle_RegWrite", 32'(d_regwrite), 0);
    check_model("byp.idle");

    // Reset asserted while three loads are draining.
    set_in(1, 9, 32'h1, 1, 11, 32'hB1); tick();
    set_in(1, 9, 32'h2, 1, 12, 32'hB2); tick();
    set_in(1, 9, 32'h3, 1, 13, 32'hB3); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    check("mid.drain_rd", 32'(d_rd), 11);
    check("mid.drain_RegWrite", 32'(d_regwrite), 1);
    q_rs = 5'd12;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid.rst_RegWrite", 32'(d_regwrite), 0);
    check("mid.rst_alu_ready", 32'(alu_ready), 0);
    check("mid.rst_mem_ready", 32'(mem_ready), 0);
    check("mid.rst_hit_rs", 32'(hit_rs), 0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid.rel_alu_ready", 32'(alu_ready), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid.post_RegWrite", 32'(d_regwrite), 0);
      check_model("mid.post");
    end

    // Back-to-back load returns across three pointer wraps.
    widx = 0;
    for (int i = 0; i < 3 * QD + 4; i++) begin
      if (i < 3 * QD) begin
        set_in(0, 0, 0, 1, 5'((i % 7) + 1), 32'h1000 + 32'(i));
        exp_rd.push_back(5'((i % 7) + 1));
        exp_dat.push_back(32'h1000 + 32'(i));
      end else begin
        set_in(0, 0, 0, 0, 0, 0);
      end
      tick();
      check_model("wrap");
      if (d_regwrite) begin
        if (widx < exp_rd.size()) begin
          check("wrap.order_rd", 32'(d_rd), 32'(exp_rd[widx]));
          check("wrap.order_in", d_in, exp_dat[widx]);
        end else begin
          check("wrap.extra_write", 32'(widx), 32'(exp_rd.size()));
        end
        widx++;
      end
    end
    check("wrap.count", 32'(widx), 32'(3 * QD));

    // Randomized traffic; a stalled offer keeps its payload until accepted.
    set_in(0, 0, 0, 0, 0, 0);
    m_acc_alu = 1'b0; m_acc_mem = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!(alu_valid && !m_acc_alu)) begin
        alu_valid = ($urandom_range(0, 99) < 50);
        alu_rd    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(mem_valid && !m_acc_mem)) begin
        mem_valid = ($urandom_range(0, 99) < ((c / 50) % 2 == 0 ? 75 : 30));
        mem_rd    = 5'($urandom_range(0, 7));
        mem_data  = $urandom;
      end
      q_rs = 5'($urandom_range(0, 7));
      q_rt = 5'($urandom_range(0, 7));
      tick();
      check_model("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
